// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wait counter must be able to hold TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Unknown funct3 codes behave as a word access.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/lsu_format.sv
// Byte-lane steering: store mask/replication and load lane select + extension.
module lsu_format
    import lsu_pkg::*;
(
    input  size_e       size_i,
    input  logic        sign_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  bmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(rdata_i >> {addr_lo_i, 3'b000});
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Size-dependent mask, store replication and load extension.
    always_comb begin
        bmask_o   = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = rdata_i;
        case (size_i)
            SZ_B: begin
                bmask_o   = 4'b0001 << addr_lo_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                bmask_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack data-memory transaction per accepted op.
// Optional build macro LSU_MISALIGN_TRAP_EN traps unaligned h/w accesses
// instead of silently dropping the offending low address bits.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_st_data,
    input  logic        i_mem_we,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic        o_timeout,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int CW = cnt_width(TIMEOUT);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     sdata_q, sdata_d;
    logic [31:0]     ld_q, ld_d;
    logic [2:0]      f3_q, f3_d;
    logic            we_q, we_d;
    logic            mis_q, mis_d;
    logic            to_q, to_d;
    logic            acc_mis;
    logic            busy;
    logic [3:0]      fmt_bmask;
    logic [31:0]     fmt_wdata;
    logic [31:0]     fmt_ld;

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_mis = ((f3_size(i_funct3) == SZ_H) && i_alu_data[0]) ||
                     ((f3_size(i_funct3) == SZ_W) && (i_alu_data[1:0] != 2'b00));
`else
    assign acc_mis = 1'b0;
`endif

    lsu_format u_fmt (
        .size_i    (f3_size(f3_q)),
        .sign_i    (f3_signed(f3_q)),
        .addr_lo_i (addr_q[1:0]),
        .st_data_i (sdata_q),
        .rdata_i   (i_mem_rdata),
        .bmask_o   (fmt_bmask),
        .wdata_o   (fmt_wdata),
        .ld_data_o (fmt_ld)
    );

    assign busy         = (state_q == BUSY);
    assign o_stall      = ((state_q == IDLE) && i_valid) || busy;
    assign o_done       = (state_q == DONE);
    assign o_ld_data    = ld_q;
    assign o_misaligned = mis_q;
    assign o_timeout    = to_q;
    assign o_mem_req    = busy;
    assign o_mem_addr   = {addr_q[31:2], 2'b00};
    assign o_mem_we     = we_q & busy;
    assign o_mem_wdata  = fmt_wdata;
    assign o_mem_bmask  = busy ? fmt_bmask : 4'b0000;

    // Next-state: accept, wait for ack or timeout, one-cycle completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        ld_d    = ld_q;
        f3_d    = f3_q;
        we_d    = we_q;
        mis_d   = mis_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    addr_d  = i_alu_data;
                    sdata_d = i_st_data;
                    we_d    = i_mem_we;
                    f3_d    = i_funct3;
                    cnt_d   = '0;
                    ld_d    = '0;
                    if (acc_mis) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    ld_d    = we_q ? 32'd0 : fmt_ld;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                ld_d    = '0;
                mis_d   = 1'b0;
                to_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-operand registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            ld_q    <= '0;
            f3_q    <= F3_W;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ld_q    <= ld_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu (TIMEOUT = 16).
module tb_lsu;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_alu_data;
    logic [31:0] i_st_data;
    logic        i_mem_we;
    logic [2:0]  i_funct3;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_ld_data;
    logic        o_misaligned;
    logic        o_timeout;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int checks;
    int failures;

    lsu #(.TIMEOUT(16)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_alu_data   (i_alu_data),
        .i_st_data    (i_st_data),
        .i_mem_we     (i_mem_we),
        .i_funct3     (i_funct3),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_ld_data    (o_ld_data),
        .o_misaligned (o_misaligned),
        .o_timeout    (o_timeout),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_mem_we     (o_mem_we),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_bmask  (o_mem_bmask),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Advance to just after the next rising edge (start of next cycle).
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Present op in cycle 0, ack in cycle 1, sample cycle 1 and cycle 2.
    task automatic do_op(input logic [31:0] a, input logic [31:0] st, input logic we,
                         input logic [2:0] f3, input logic [31:0] rd,
                         output logic stall0, output logic req1, output logic [31:0] addr1,
                         output logic [31:0] wd1, output logic [3:0] bm1, output logic we1,
                         output logic done2, output logic stall2, output logic [31:0] ld2);
        i_valid = 1'b1; i_alu_data = a; i_st_data = st; i_mem_we = we; i_funct3 = f3;
        @(negedge i_clk);
        stall0 = o_stall;
        next_cycle();
        i_valid = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = rd;
        @(negedge i_clk);
        req1 = o_mem_req; addr1 = o_mem_addr; wd1 = o_mem_wdata; bm1 = o_mem_bmask; we1 = o_mem_we;
        next_cycle();
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        done2 = o_done; stall2 = o_stall; ld2 = o_ld_data;
        next_cycle();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #12;
        checks++;
        if ({o_stall, o_done, o_mem_req, o_misaligned, o_timeout, o_mem_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000",
                     {o_stall, o_done, o_mem_req, o_misaligned, o_timeout, o_mem_we});
        end
        checks++;
        if ({o_ld_data, o_mem_addr, o_mem_wdata, o_mem_bmask} !== 100'd0) begin
            failures++;
            $display("FAIL reset_data: ld=%h addr=%h wdata=%h bmask=%b want zeros",
                     o_ld_data, o_mem_addr, o_mem_wdata, o_mem_bmask);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_ext();
        logic s0, r1, w1, d2, s2;
        logic [31:0] a1, wd1, ld2;
        logic [3:0] bm1;
        do_op(32'h0000_0103, 32'h0, 1'b0, 3'b000, 32'h80FF_1234, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (!(s0 === 1'b1 && r1 === 1'b1 && d2 === 1'b1 && s2 === 1'b0)) begin
            failures++;
            $display("FAIL lb_timing: stall0=%b req1=%b done2=%b stall2=%b want 1 1 1 0", s0, r1, d2, s2);
        end
        checks++;
        if (ld2 !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb_data: got %h want ffffff80", ld2);
        end
        checks++;
        if (bm1 !== 4'b1000 || a1 !== 32'h0000_0100) begin
            failures++;
            $display("FAIL lb_bus: bmask=%b addr=%h want 1000 00000100", bm1, a1);
        end
        do_op(32'h0000_0103, 32'h0, 1'b0, 3'b100, 32'h80FF_1234, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (ld2 !== 32'h0000_0080 || d2 !== 1'b1) begin
            failures++;
            $display("FAIL lbu_data: got %h done=%b want 00000080 1", ld2, d2);
        end
        do_op(32'h0000_0102, 32'h0, 1'b0, 3'b001, 32'h8001_7FFF, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (ld2 !== 32'hFFFF_8001) begin
            failures++;
            $display("FAIL lh_data: got %h want ffff8001", ld2);
        end
        do_op(32'h0000_0100, 32'h0, 1'b0, 3'b101, 32'h8001_F00D, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (ld2 !== 32'h0000_F00D) begin
            failures++;
            $display("FAIL lhu_data: got %h want 0000f00d", ld2);
        end
    endtask

    task automatic test_store();
        logic s0, r1, w1, d2, s2;
        logic [31:0] a1, wd1, ld2;
        logic [3:0] bm1;
        do_op(32'h0000_0102, 32'h1234_ABCD, 1'b1, 3'b001, 32'hFFFF_FFFF, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (a1 !== 32'h0000_0100 || bm1 !== 4'b1100 || wd1 !== 32'hABCD_ABCD || w1 !== 1'b1) begin
            failures++;
            $display("FAIL sh_bus: addr=%h bmask=%b wdata=%h we=%b want 00000100 1100 abcdabcd 1",
                     a1, bm1, wd1, w1);
        end
        checks++;
        if (ld2 !== 32'h0 || d2 !== 1'b1) begin
            failures++;
            $display("FAIL sh_done: ld=%h done=%b want 00000000 1", ld2, d2);
        end
        do_op(32'h0000_0201, 32'h0000_005A, 1'b1, 3'b000, 32'h0, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (a1 !== 32'h0000_0200 || bm1 !== 4'b0010 || wd1 !== 32'h5A5A_5A5A) begin
            failures++;
            $display("FAIL sb_bus: addr=%h bmask=%b wdata=%h want 00000200 0010 5a5a5a5a", a1, bm1, wd1);
        end
        do_op(32'h0000_0300, 32'hCAFE_BABE, 1'b1, 3'b111, 32'h0, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (bm1 !== 4'b1111 || wd1 !== 32'hCAFE_BABE) begin
            failures++;
            $display("FAIL sw_f3_other: bmask=%b wdata=%h want 1111 cafebabe", bm1, wd1);
        end
    endtask

    task automatic test_delayed_ack();
        int bad;
        bad = 0;
        i_valid = 1'b1; i_alu_data = 32'h0000_0400; i_mem_we = 1'b0; i_funct3 = 3'b010;
        i_st_data = 32'h0;
        @(negedge i_clk);
        if (o_stall !== 1'b1) bad++;
        next_cycle();
        i_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin
                i_mem_ack = 1'b1;
                i_mem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge i_clk);
            if (o_mem_req !== 1'b1 || o_stall !== 1'b1 || o_mem_addr !== 32'h0000_0400 ||
                o_mem_bmask !== 4'b1111 || o_mem_we !== 1'b0 || o_done !== 1'b0) bad++;
            next_cycle();
        end
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lw_wait_stable: %0d bad cycles want 0", bad);
        end
        checks++;
        if (o_done !== 1'b1 || o_stall !== 1'b0 || o_ld_data !== 32'hDEAD_BEEF || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL lw_wait_done: done=%b stall=%b ld=%h req=%b want 1 0 deadbeef 0",
                     o_done, o_stall, o_ld_data, o_mem_req);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        int reqs;
        reqs = 0;
        i_valid = 1'b1; i_alu_data = 32'h0000_0500; i_mem_we = 1'b0; i_funct3 = 3'b010;
        next_cycle();
        i_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge i_clk);
            if (o_mem_req === 1'b1 && o_done === 1'b0) reqs++;
            next_cycle();
        end
        checks++;
        if (reqs != 16) begin
            failures++;
            $display("FAIL to_req_cycles: got %0d want 16", reqs);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_timeout !== 1'b1 || o_ld_data !== 32'h0 || o_mem_req !== 1'b0 ||
            o_misaligned !== 1'b0) begin
            failures++;
            $display("FAIL to_done: done=%b to=%b ld=%h req=%b mis=%b want 1 1 0 0 0",
                     o_done, o_timeout, o_ld_data, o_mem_req, o_misaligned);
        end
        next_cycle();
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h1111_1111;
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_timeout !== 1'b0 || o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
            failures++;
            $display("FAIL late_ack: done=%b to=%b req=%b stall=%b want 0 0 0 0",
                     o_done, o_timeout, o_mem_req, o_stall);
        end
        next_cycle();
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0 || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL late_ack_after: done=%b req=%b want 0 0", o_done, o_mem_req);
        end
        next_cycle();
    endtask

    task automatic test_misalign();
        i_valid = 1'b1; i_alu_data = 32'h0000_0102; i_mem_we = 1'b0; i_funct3 = 3'b010;
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b1) begin
            failures++;
            $display("FAIL mis_stall0: got %b want 1", o_stall);
        end
        next_cycle();
        i_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_misaligned !== 1'b1 || o_mem_req !== 1'b0 || o_stall !== 1'b0 ||
            o_timeout !== 1'b0 || o_ld_data !== 32'h0) begin
            failures++;
            $display("FAIL mis_trap: done=%b mis=%b req=%b stall=%b to=%b ld=%h want 1 1 0 0 0 0",
                     o_done, o_misaligned, o_mem_req, o_stall, o_timeout, o_ld_data);
        end
        next_cycle();
`else
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h0BAD_F00D;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_0100 || o_mem_bmask !== 4'b1111) begin
            failures++;
            $display("FAIL mis_noop_bus: req=%b addr=%h bmask=%b want 1 00000100 1111",
                     o_mem_req, o_mem_addr, o_mem_bmask);
        end
        next_cycle();
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_misaligned !== 1'b0 || o_ld_data !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL mis_noop_done: done=%b mis=%b ld=%h want 1 0 0badf00d",
                     o_done, o_misaligned, o_ld_data);
        end
        next_cycle();
`endif
    endtask

    task automatic test_back_to_back();
        i_valid = 1'b1; i_alu_data = 32'h0000_0600; i_mem_we = 1'b0; i_funct3 = 3'b010;
        next_cycle();
        i_valid = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0006;
        next_cycle();
        // cycle 2: DONE with a new op already presented
        i_mem_ack = 1'b0;
        i_valid = 1'b1; i_alu_data = 32'h0000_0700;
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b1 || o_stall !== 1'b0 || o_ld_data !== 32'h0000_0006) begin
            failures++;
            $display("FAIL b2b_done: done=%b stall=%b ld=%h want 1 0 00000006", o_done, o_stall, o_ld_data);
        end
        next_cycle();
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b1 || o_mem_req !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: stall=%b req=%b done=%b want 1 0 0", o_stall, o_mem_req, o_done);
        end
        next_cycle();
        i_valid = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0007;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_0700) begin
            failures++;
            $display("FAIL b2b_second_req: req=%b addr=%h want 1 00000700", o_mem_req, o_mem_addr);
        end
        next_cycle();
        i_mem_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_busy();
        logic s0, r1, w1, d2, s2;
        logic [31:0] a1, wd1, ld2;
        logic [3:0] bm1;
        i_valid = 1'b1; i_alu_data = 32'h0000_0800; i_mem_we = 1'b1; i_st_data = 32'h5555_AAAA;
        i_funct3 = 3'b010;
        next_cycle();
        i_valid = 1'b0;
        next_cycle();
        #2;
        checks++;
        if (o_mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstbusy_pre: req=%b want 1", o_mem_req);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_mem_req !== 1'b0 || o_stall !== 1'b0 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0 ||
            o_mem_bmask !== 4'b0000 || o_mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL rstbusy_async: req=%b stall=%b we=%b addr=%h bmask=%b wdata=%h want zeros",
                     o_mem_req, o_stall, o_mem_we, o_mem_addr, o_mem_bmask, o_mem_wdata);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        next_cycle();
        do_op(32'h0000_0900, 32'h0, 1'b0, 3'b010, 32'h1357_9BDF, s0, r1, a1, wd1, bm1, w1, d2, s2, ld2);
        checks++;
        if (r1 !== 1'b1 || a1 !== 32'h0000_0900 || d2 !== 1'b1 || ld2 !== 32'h1357_9BDF) begin
            failures++;
            $display("FAIL rstbusy_after: req=%b addr=%h done=%b ld=%h want 1 00000900 1 13579bdf",
                     r1, a1, d2, ld2);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        i_valid = 1'b0; i_alu_data = 32'h0; i_st_data = 32'h0; i_mem_we = 1'b0;
        i_funct3 = 3'b000; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        test_reset();
        test_load_ext();
        test_store();
        test_delayed_ack();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the execute/memory path. Takes the ALU result as the effective address, plus rs2 data and funct3, and runs one data-memory transaction over a req/ack bus. Handles byte-lane steering, byte masks and load sign/zero extension. Stalls the pipeline until the access completes or times out.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles without `i_mem_ack` before the access is abandoned (≥1).
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: a memory op is presented this cycle.
- `i_alu_data` in 32: effective address from the ALU.
- `i_st_data` in 32: store data (rs2).
- `i_mem_we` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu. Other codes are treated as 010.
- `o_stall` out 1: hold the pipeline.
- `o_done` out 1: one-cycle completion pulse.
- `o_ld_data` out 32: formatted load result, valid with `o_done`.
- `o_misaligned` out 1: alignment fault, valid with `o_done`.
- `o_timeout` out 1: timeout fault, valid with `o_done`.
- `o_mem_req` out 1: bus request.
- `o_mem_addr` out 32: word-aligned address, `[1:0]` = 00.
- `o_mem_we` out 1: bus write enable.
- `o_mem_wdata` out 32: lane-replicated store data.
- `o_mem_bmask` out 4: byte enables.
- `i_mem_ack` in 1: bus completion.
- `i_mem_rdata` in 32: read word, valid with ack.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - With `i_valid`=1, latch address, data, we and funct3.
  - Go to BUSY, or to DONE if misaligned (see Configuration).
- BUSY
  - `o_mem_req`=1. All `o_mem_*` come from latched registers and are stable until ack.
  - On `i_mem_ack`: capture formatted `i_mem_rdata` (loads) and go to DONE.
  - Otherwise increment the wait counter. When it reaches `TIMEOUT`, go to DONE with the timeout flag set.
- DONE
  - `o_done`=1 for one cycle, then return to IDLE.
  - `i_valid` in DONE is ignored; the pipeline advances this cycle.
- `o_stall` is combinational: (IDLE & `i_valid`) | BUSY. It is 0 in DONE.
- Byte mask:
  - b: 0001 << a[1:0].
  - h: 0011 << {a[1],0}.
  - w: 1111.
  - For loads the mask is still driven; the bus ignores it when `o_mem_we`=0.
- Store data: b replicated ×4, h replicated ×2, w as is.
- Load format:
  - Select the lane by a[1:0] (b) or a[1] (h).
  - Sign-extend for b/h; zero-extend for bu/hu.
  - `o_ld_data` = 0 for stores, faults and timeouts.
- Fault flags are mutually exclusive and cleared on return to IDLE.
- An ack arriving in IDLE or DONE is ignored.
- Reset (any state, asynchronous):
  - State IDLE, counter 0.
  - `o_mem_req`, `o_done`, `o_misaligned`, `o_timeout` = 0.
  - `o_ld_data`, `o_mem_addr`, `o_mem_wdata` = 0; `o_mem_bmask` = 0000; `o_mem_we` = 0.
  - `o_stall` = 0 only when `i_valid` = 0.

## Timing
- Accept in cycle 0. `o_mem_req` is asserted from cycle 1.
- Ack in BUSY cycle k (k≥1): `o_done` in cycle k+1, `o_stall` high for cycles 0..k. Minimum latency is 2 cycles (ack in cycle 1, done in cycle 2).
- Timeout: with no ack, `o_mem_req` is high for exactly `TIMEOUT` cycles, then DONE.
- Misaligned trap: no request is issued. `o_done` comes in cycle 1; `o_stall` is high in cycle 0 only.
- Back-to-back ops: at most one op is accepted every 3 cycles (IDLE→BUSY→DONE).

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with a[0]=1, or a word access with a[1:0]≠00, goes IDLE→DONE with `o_misaligned`=1.
  - No bus request is made; stores are suppressed.
- Not defined:
  - Offending low address bits are ignored (h forces a[0]=0, w forces a[1:0]=00).
  - The access proceeds normally; `o_misaligned` is tied to 0.

## Structure
- `lsu_pkg` holds:
  - the state enum (IDLE, BUSY, DONE);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the counter width function, $clog2(TIMEOUT+1).
- Sub-module `lsu_format` (combinational) produces bmask, wdata and the extended load data from size, sign, a[1:0], st_data and rdata. The FSM, counter and registers stay in `lsu`.

## Test plan
- lb at 0x0000_0103, rdata 0x80FF_1234, ack in cycle 1 → `o_ld_data`=0xFFFF_FF80, `o_done` in cycle 2. Same access as lbu → 0x0000_0080.
- sh at 0x0000_0102, st_data 0x1234_ABCD → `o_mem_addr`=0x0000_0100, bmask 1100, wdata 0xABCD_ABCD, `o_mem_we`=1.
- lw with ack delayed to BUSY cycle 5 → all `o_mem_*` stable for cycles 1–5, `o_stall` high for cycles 0–5, `o_done` in cycle 6.
- No ack, TIMEOUT=16 → req high for cycles 1–16, `o_done` and `o_timeout` in cycle 17, `o_ld_data`=0. A late ack in cycle 18 is ignored.
- lw at 0x0000_0102:
  - with `LSU_MISALIGN_TRAP_EN` → no req, `o_misaligned`=1 in cycle 1;
  - without it → req at 0x0000_0100, `o_misaligned`=0.
- `i_rst_n` low in BUSY cycle 2 → `o_mem_req`=0 immediately. After release, a new lw completes normally.
